p4_router_vnp4_meta_rx: RTL and testbench

P4_ROUTER_VNP4_META_RX -- requirements
Module: p4_router_vnp4_meta_rx

---
 rtl/p4_router_vnp4_meta_rx.sv | 139 +++++++++++++
 tb/tb_p4_router_vnp4_meta_rx.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p4_router_vnp4_meta_rx.sv
// Routes VNP4 packets to one of NUM_PORTS egress ports using queued per-packet metadata.
// Optional byte-length check: define P4_ROUTER_META_RX_LEN_CHECK_EN.
module p4_router_vnp4_meta_rx #(
  parameter int NUM_PORTS       = 4,
  parameter int META_FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 s_meta_valid,
  input  logic [32:0]          s_meta,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  input  logic [511:0]         s_axis_tdata,
  input  logic [63:0]          s_axis_tkeep,
  output logic [NUM_PORTS-1:0] m_axis_tvalid,
  input  logic [NUM_PORTS-1:0] m_axis_tready,
  output logic [511:0]         m_axis_tdata,
  output logic [63:0]          m_axis_tkeep,
  output logic                 m_axis_tlast,
  output logic [2:0]           m_axis_prio,
  output logic [31:0]          drop_count,
  output logic [31:0]          len_err_count,
  output logic                 meta_overflow
);
  localparam int          AW      = $clog2(META_FIFO_DEPTH);
  localparam int          PW      = $clog2(NUM_PORTS);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(META_FIFO_DEPTH);
  localparam logic [7:0]  NP_C    = 8'(NUM_PORTS);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_e;

  state_e        state_q;
  logic [32:0]   mem_q [META_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [PW-1:0] port_q;
  logic [2:0]    prio_q;
  logic          ovf_q;
  logic [31:0]   drop_q;

  logic [32:0] head;
  logic        full, empty, push, pop, beat_acc, last_acc;

  assign head     = mem_q[rd_ptr_q];
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign beat_acc = s_axis_tvalid & s_axis_tready;
  assign last_acc = beat_acc & s_axis_tlast;
  // s_axis_tready is only high in FWD/DROP, so a last beat always has a head entry to retire.
  assign pop      = last_acc;
  assign push     = s_meta_valid & (~full | pop);

  always_comb begin
    m_axis_tvalid = '0;
    s_axis_tready = 1'b0;
    case (state_q)
      FWD: begin
        m_axis_tvalid[port_q] = s_axis_tvalid;
        s_axis_tready         = m_axis_tready[port_q];
      end
      DROP:    s_axis_tready = 1'b1;
      default: ;
    endcase
  end

  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_prio   = prio_q;
  assign drop_count    = drop_q;
  assign meta_overflow = ovf_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_meta;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      port_q   <= '0;
      prio_q   <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
      if (s_meta_valid && full && !pop) ovf_q <= 1'b1;
      case (state_q)
        IDLE: if (!empty) begin
          port_q  <= head[17+PW-1:17];
          prio_q  <= head[16:14];
          state_q <= (head[24:17] < NP_C) ? FWD : DROP;
        end
        FWD: if (last_acc) state_q <= IDLE;
        DROP: if (last_acc) begin
          state_q <= IDLE;
          if (drop_q != '1) drop_q <= drop_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef P4_ROUTER_META_RX_LEN_CHECK_EN
  logic [13:0] len_q, byte_cnt_q, byte_sum;
  logic [31:0] len_err_q;
  logic        unused_meta;

  assign unused_meta   = ^head[32:25];
  assign byte_sum      = byte_cnt_q + 14'($countones(s_axis_tkeep));
  assign len_err_count = len_err_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      len_q      <= '0;
      byte_cnt_q <= '0;
      len_err_q  <= '0;
    end else begin
      if (state_q == IDLE && !empty) len_q <= head[13:0];
      if (last_acc) begin
        byte_cnt_q <= '0;
        if (byte_sum != len_q && len_err_q != '1) len_err_q <= len_err_q + 1'b1;
      end else if (beat_acc) begin
        byte_cnt_q <= byte_sum;
      end
    end
  end
`else
  logic unused_meta;
  assign unused_meta   = ^{head[32:25], head[13:0]};
  assign len_err_count = '0;
`endif

endmodule

// File: tb/tb_p4_router_vnp4_meta_rx.sv
// Scoreboard bench for p4_router_vnp4_meta_rx: queue-based reference model, randomized packets.
module tb_p4_router_vnp4_meta_rx;
  localparam int NP    = 4;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            arst_n = 1'b0;
  logic            s_meta_valid;
  logic [32:0]     s_meta;
  logic            s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [511:0]    s_axis_tdata;
  logic [63:0]     s_axis_tkeep;
  logic [NP-1:0]   m_axis_tvalid, m_axis_tready;
  logic [511:0]    m_axis_tdata;
  logic [63:0]     m_axis_tkeep;
  logic            m_axis_tlast;
  logic [2:0]      m_axis_prio;
  logic [31:0]     drop_count, len_err_count;
  logic            meta_overflow;

  p4_router_vnp4_meta_rx #(.NUM_PORTS(NP), .META_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .arst_n(arst_n),
    .s_meta_valid(s_meta_valid), .s_meta(s_meta),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_prio(m_axis_prio), .drop_count(drop_count), .len_err_count(len_err_count),
    .meta_overflow(meta_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]   port;
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
    logic [2:0]   prio;
  } beat_t;

  beat_t       exp_q[$];
  logic [32:0] meta_model[$];
  int          checks = 0, errors = 0;
  int          exp_drop = 0, exp_len_err = 0;
  logic        exp_ovf = 1'b0;
  int          cyc = 0, stall_end = 0, stall_seen = 0;
  bit          rand_rdy = 1'b0, gaps = 1'b0;
  beat_t       mon_e;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic abort_run(input string what);
    checks++;
    errors++;
    $display("FAIL timeout %s", what);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Egress ready: forced stall window on port 1, otherwise all-ready or random.
  initial begin
    m_axis_tready = '1;
    forever begin
      @(posedge clk);
      #2;
      if (cyc < stall_end) m_axis_tready = 4'b1101;
      else if (rand_rdy) for (int p = 0; p < NP; p++) m_axis_tready[p] = ($urandom_range(3) != 0);
      else m_axis_tready = '1;
    end
  end

  // Monitor: every accepted egress beat is checked against the scoreboard head.
  always @(negedge clk) begin
    if (arst_n) begin
      chk("tvalid_onehot", 512'($countones(m_axis_tvalid) <= 1), 512'(1));
      for (int p = 0; p < NP; p++) begin
        if (m_axis_tvalid[p]) begin
          chk("tready_follow", 512'(s_axis_tready), 512'(m_axis_tready[p]));
          if (p == 1 && !m_axis_tready[p]) stall_seen++;
          if (m_axis_tready[p]) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_beat: got beat on port %0d expected none", p);
            end else begin
              mon_e = exp_q.pop_front();
              chk("beat_port", 512'(p), 512'(mon_e.port));
              chk("beat_data", m_axis_tdata, mon_e.data);
              chk("beat_keep", 512'(m_axis_tkeep), 512'(mon_e.keep));
              chk("beat_last", 512'(m_axis_tlast), 512'(mon_e.last));
              chk("beat_prio", 512'(m_axis_prio), 512'(mon_e.prio));
            end
          end
        end
      end
    end
  end

  task automatic push_meta(input logic [7:0] egr, input logic [2:0] prio, input logic [13:0] len);
    logic [32:0] m;
    m = {8'($urandom), egr, prio, len};
    s_meta = m;
    s_meta_valid = 1'b1;
    @(posedge clk);
    #1;
    s_meta_valid = 1'b0;
    if (meta_model.size() < DEPTH) meta_model.push_back(m);
    else exp_ovf = 1'b1;
  endtask

  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic last,
                           input bit pulse, input logic [32:0] pm);
    bit acc;
    int n;
    s_axis_tdata = d;
    s_axis_tkeep = k;
    s_axis_tlast = last;
    s_axis_tvalid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc) begin
      @(negedge clk);
      acc = s_axis_tready;
      if (acc && pulse) begin
        s_meta = pm;
        s_meta_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      s_meta_valid = 1'b0;
      n++;
      if (n > 500) begin
        abort_run("beat_accept");
        return;
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_packet(input int nbeats, input int last_bytes, input bit pulse,
                             input logic [32:0] pm, input int abort_at);
    logic [32:0]  m;
    logic [511:0] d[$];
    logic [63:0]  k[$];
    logic [511:0] dd;
    logic [63:0]  kk;
    beat_t        e;
    int           total;
    m = meta_model.pop_front();
    total = 0;
    for (int b = 0; b < nbeats; b++) begin
      for (int w = 0; w < 16; w++) dd[w*32 +: 32] = $urandom;
      kk = '1;
      if (b == nbeats - 1) for (int i = 0; i < 64; i++) kk[i] = (i < last_bytes);
      d.push_back(dd);
      k.push_back(kk);
      total += $countones(kk);
      if (m[24:17] < NP) begin
        e.port = m[24:17];
        e.data = dd;
        e.keep = kk;
        e.last = (b == nbeats - 1);
        e.prio = m[16:14];
        exp_q.push_back(e);
      end
    end
    if (abort_at < 0) begin
      if (m[24:17] >= NP) exp_drop++;
`ifdef P4_ROUTER_META_RX_LEN_CHECK_EN
      if (14'(total) != m[13:0]) exp_len_err++;
`endif
    end
    for (int b = 0; b < nbeats; b++) begin
      if (b == abort_at) begin
        s_axis_tdata = d[b];
        s_axis_tkeep = k[b];
        s_axis_tlast = (b == nbeats - 1);
        s_axis_tvalid = 1'b1;
        arst_n = 1'b0;
        #1;
        chk("rst_mid_s_tready", 512'(s_axis_tready), 512'(0));
        chk("rst_mid_m_tvalid", 512'(m_axis_tvalid), 512'(0));
        chk("rst_mid_drop", 512'(drop_count), 512'(0));
        chk("rst_mid_lenerr", 512'(len_err_count), 512'(0));
        chk("rst_mid_ovf", 512'(meta_overflow), 512'(0));
        s_axis_tvalid = 1'b0;
        exp_q.delete();
        meta_model.delete();
        exp_drop = 0;
        exp_len_err = 0;
        exp_ovf = 1'b0;
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        return;
      end
      if (gaps && $urandom_range(3) == 0) begin
        s_axis_tvalid = 1'b0;
        repeat ($urandom_range(2, 1)) @(posedge clk);
        #1;
      end
      send_beat(d[b], k[b], (b == nbeats - 1), pulse && (b == nbeats - 1), pm);
    end
    if (pulse) begin
      if (meta_model.size() < DEPTH) meta_model.push_back(pm);
      else exp_ovf = 1'b1;
    end
  endtask

  initial begin
    #500000;
    abort_run("global_watchdog");
  end

  initial begin
    logic [32:0] pm;
    int          base, nb, lb, len;
    s_meta_valid = 1'b0;
    s_meta = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_s_tready", 512'(s_axis_tready), 512'(0));
    chk("reset_m_tvalid", 512'(m_axis_tvalid), 512'(0));
    chk("reset_drop", 512'(drop_count), 512'(0));
    chk("reset_lenerr", 512'(len_err_count), 512'(0));
    chk("reset_ovf", 512'(meta_overflow), 512'(0));
    arst_n = 1'b1;
    @(posedge clk);
    #1;

    // Forward to port 2, two full beats.
    push_meta(8'd2, 3'd5, 14'd128);
    send_packet(2, 64, 1'b0, '0, -1);
    chk("fwd_drop", 512'(drop_count), 512'(0));

    // Out-of-range egress port is dropped.
    push_meta(8'd7, 3'd1, 14'd192);
    send_packet(3, 64, 1'b0, '0, -1);
    chk("drop_count_1", 512'(drop_count), 512'(1));

    // Full FIFO: push coinciding with a pop is accepted.
    for (int i = 0; i < 4; i++) push_meta(8'($urandom_range(0, 3)), 3'($urandom), 14'd64);
    pm = {8'd9, 8'd3, 3'd6, 14'd64};
    send_packet(1, 64, 1'b1, pm, -1);
    chk("push_pop_full_ovf", 512'(meta_overflow), 512'(0));
    for (int i = 0; i < 4; i++) send_packet(1, 64, 1'b0, '0, -1);

    // Five metas into a four-deep FIFO.
    for (int i = 0; i < 5; i++) push_meta(8'(i), 3'(i), 14'd128);
    chk("overflow_set", 512'(meta_overflow), 512'(1));
    for (int i = 0; i < 4; i++) send_packet(2, 64, 1'b0, '0, -1);
    chk("overflow_sticky", 512'(meta_overflow), 512'(exp_ovf));

    // Byte-length check: 94 bytes against 100 then 94.
    push_meta(8'd1, 3'd0, 14'd100);
    send_packet(2, 30, 1'b0, '0, -1);
    chk("lenerr_mismatch", 512'(len_err_count), 512'(exp_len_err));
    push_meta(8'd1, 3'd0, 14'd94);
    send_packet(2, 30, 1'b0, '0, -1);
    chk("lenerr_match", 512'(len_err_count), 512'(exp_len_err));

    // Port 1 backpressure for 10 cycles mid-packet.
    base = stall_seen;
    push_meta(8'd1, 3'd4, 14'd384);
    fork
      send_packet(6, 64, 1'b0, '0, -1);
      begin
        repeat (3) @(posedge clk);
        #1;
        stall_end = cyc + 10;
      end
    join
    chk("stall_cycles", 512'(stall_seen - base), 512'(10));

    // Randomized traffic.
    rand_rdy = 1'b1;
    gaps = 1'b1;
    for (int i = 0; i < 60; i++) begin
      nb = $urandom_range(4, 1);
      lb = $urandom_range(64, 1);
      len = ($urandom_range(1) == 0) ? (nb - 1) * 64 + lb : $urandom_range(400);
      push_meta(8'($urandom_range(7)), 3'($urandom), 14'(len));
      send_packet(nb, lb, 1'b0, '0, -1);
    end
    rand_rdy = 1'b0;
    gaps = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rand_all_beats_seen", 512'(exp_q.size()), 512'(0));
    chk("rand_drop", 512'(drop_count), 512'(exp_drop));
    chk("rand_lenerr", 512'(len_err_count), 512'(exp_len_err));
    chk("rand_ovf", 512'(meta_overflow), 512'(exp_ovf));

    // Reset during beat 2 of 4, then a fresh packet.
    push_meta(8'd3, 3'd2, 14'd256);
    send_packet(4, 64, 1'b0, '0, 1);
    push_meta(8'd0, 3'd6, 14'd100);
    send_packet(2, 36, 1'b0, '0, -1);
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_beats_seen", 512'(exp_q.size()), 512'(0));
    chk("post_rst_drop", 512'(drop_count), 512'(exp_drop));
    chk("post_rst_ovf", 512'(meta_overflow), 512'(exp_ovf));
    chk("post_rst_lenerr", 512'(len_err_count), 512'(exp_len_err));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
